// File: rtl/cal_job_ctrl.sv
// ============================================================================
// Module      : cal_job_ctrl
// Description : Iterative shift-add multiply job controller feeding the
//               cal_state register block (busy / sticky-done handshake).
//               Optional one-entry start queue: CAL_JOB_CTRL_START_QUEUE_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cal_job_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   op_a,
    input  logic [DATA_WIDTH-1:0]   op_b,
    input  logic                    abort,
    input  logic                    busy_rd,
    output logic                    start_ack,
    output logic                    busy,
    output logic [2*DATA_WIDTH-1:0] result,
    output logic                    result_vld,
    output logic                    done_sticky
);

    localparam int               RES_W    = 2 * DATA_WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [RES_W-1:0]        a_sh_q, a_sh_d;
    logic [DATA_WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [RES_W-1:0]        acc_q, acc_d;
    logic [RES_W-1:0]        result_q, result_d;
    logic                    start_ack_q, start_ack_d;
    logic                    busy_q, busy_d;
    logic                    result_vld_q, result_vld_d;
    logic                    done_sticky_q, done_sticky_d;

`ifdef CAL_JOB_CTRL_START_QUEUE_EN
    logic                    pend_vld_q, pend_vld_d;
    logic [DATA_WIDTH-1:0]   pend_a_q, pend_a_d;
    logic [DATA_WIDTH-1:0]   pend_b_q, pend_b_d;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        a_sh_d        = a_sh_q;
        b_sh_d        = b_sh_q;
        acc_d         = acc_q;
        result_d      = result_q;
        start_ack_d   = 1'b0;
        result_vld_d  = 1'b0;
        done_sticky_d = done_sticky_q & ~busy_rd;
`ifdef CAL_JOB_CTRL_START_QUEUE_EN
        pend_vld_d    = pend_vld_q;
        pend_a_d      = pend_a_q;
        pend_b_d      = pend_b_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d     = ST_RUN;
                    a_sh_d      = {{DATA_WIDTH{1'b0}}, op_a};
                    b_sh_d      = op_b;
                    cnt_d       = '0;
                    acc_d       = '0;
                    start_ack_d = 1'b1;
                end
            end

            ST_RUN: begin
                if (abort) begin
                    state_d    = ST_IDLE;
`ifdef CAL_JOB_CTRL_START_QUEUE_EN
                    pend_vld_d = 1'b0;
`endif
                end else begin
                    if (b_sh_q[0]) begin
                        acc_d = acc_q + a_sh_q;
                    end
                    a_sh_d = a_sh_q << 1;
                    b_sh_d = b_sh_q >> 1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    // Final iteration: publish the sum including this cycle's add
                    if (cnt_q == CNT_LAST) begin
                        state_d       = ST_DONE;
                        result_d      = acc_d;
                        result_vld_d  = 1'b1;
                        done_sticky_d = 1'b1;
                    end
`ifdef CAL_JOB_CTRL_START_QUEUE_EN
                    if (start && !pend_vld_q) begin
                        pend_vld_d  = 1'b1;
                        pend_a_d    = op_a;
                        pend_b_d    = op_b;
                        start_ack_d = 1'b1;
                    end
`endif
                end
            end

            ST_DONE: begin
                // Holding the set through DONE lets it win over a coincident busy_rd
                done_sticky_d = 1'b1;
                state_d       = ST_IDLE;
`ifdef CAL_JOB_CTRL_START_QUEUE_EN
                if (pend_vld_q) begin
                    state_d    = ST_RUN;
                    a_sh_d     = {{DATA_WIDTH{1'b0}}, pend_a_q};
                    b_sh_d     = pend_b_q;
                    cnt_d      = '0;
                    acc_d      = '0;
                    pend_vld_d = 1'b0;
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            a_sh_q        <= '0;
            b_sh_q        <= '0;
            acc_q         <= '0;
            result_q      <= '0;
            start_ack_q   <= 1'b0;
            busy_q        <= 1'b0;
            result_vld_q  <= 1'b0;
            done_sticky_q <= 1'b0;
`ifdef CAL_JOB_CTRL_START_QUEUE_EN
            pend_vld_q    <= 1'b0;
            pend_a_q      <= '0;
            pend_b_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            a_sh_q        <= a_sh_d;
            b_sh_q        <= b_sh_d;
            acc_q         <= acc_d;
            result_q      <= result_d;
            start_ack_q   <= start_ack_d;
            busy_q        <= busy_d;
            result_vld_q  <= result_vld_d;
            done_sticky_q <= done_sticky_d;
`ifdef CAL_JOB_CTRL_START_QUEUE_EN
            pend_vld_q    <= pend_vld_d;
            pend_a_q      <= pend_a_d;
            pend_b_q      <= pend_b_d;
`endif
        end
    end

    assign start_ack   = start_ack_q;
    assign busy        = busy_q;
    assign result      = result_q;
    assign result_vld  = result_vld_q;
    assign done_sticky = done_sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_cal_job_ctrl.sv
// ============================================================================
// Module      : tb_cal_job_ctrl
// Description : Scoreboard bench for cal_job_ctrl against a job-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cal_job_ctrl;

    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [DW-1:0]   op_a = '0;
    logic [DW-1:0]   op_b = '0;
    logic            abort = 1'b0;
    logic            busy_rd = 1'b0;
    logic            start_ack;
    logic            busy;
    logic [2*DW-1:0] result;
    logic            result_vld;
    logic            done_sticky;

    cal_job_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op_a        (op_a),
        .op_b        (op_b),
        .abort       (abort),
        .busy_rd     (busy_rd),
        .start_ack   (start_ack),
        .busy        (busy),
        .result      (result),
        .result_vld  (result_vld),
        .done_sticky (done_sticky)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    // Job-level reference: a job is a countdown of DW busy cycles carrying a*b
    bit              m_active, m_done, m_pend, m_sticky;
    int              m_left;
    logic [2*DW-1:0] m_prod, m_pend_prod, m_result;
    bit              exp_ack, exp_busy, exp_vld;
    logic [2*DW-1:0] exp_q[$];

    task automatic model_update(input logic s, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic ab, input logic rd, input logic r);
        logic [2*DW-1:0] p;
        p        = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        exp_ack  = 1'b0;
        exp_vld  = 1'b0;
        if (r) begin
            m_active = 0; m_done = 0; m_pend = 0; m_sticky = 0; m_left = 0;
            m_result = '0;
            exp_q.delete();
        end else begin
            m_sticky = m_sticky && !rd;
            if (m_done) begin
                m_done   = 0;
                m_sticky = 1;
                if (m_pend) begin
                    m_active = 1; m_left = DW; m_prod = m_pend_prod; m_pend = 0;
                end
            end else if (m_active) begin
                if (ab) begin
                    m_active = 0; m_pend = 0;
                end else begin
`ifdef CAL_JOB_CTRL_START_QUEUE_EN
                    if (s && !m_pend) begin
                        m_pend = 1; m_pend_prod = p; exp_ack = 1;
                    end
`endif
                    m_left--;
                    if (m_left == 0) begin
                        m_active = 0; m_done = 1; m_result = m_prod;
                        exp_vld = 1; m_sticky = 1;
                        exp_q.push_back(m_prod);
                    end
                end
            end else if (s && !ab) begin
                m_active = 1; m_left = DW; m_prod = p; exp_ack = 1;
            end
        end
        exp_busy = m_active;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle control checks plus result scoreboard on result_vld
    always @(negedge clk) begin
        if (chk_en) begin
            chk("start_ack", 64'(start_ack), 64'(exp_ack));
            chk("busy", 64'(busy), 64'(exp_busy));
            chk("done_sticky", 64'(done_sticky), 64'(m_sticky));
            chk("result_vld", 64'(result_vld), 64'(exp_vld));
            chk("result_hold", 64'(result), 64'(m_result));
            if (result_vld === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'(result), 64'hDEAD_0000_0000);
                end else begin
                    chk("result_value", 64'(result), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic step(input logic s, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic ab, input logic rd, input logic r);
        start = s; op_a = a; op_b = b; abort = ab; busy_rd = rd; rst = r;
        @(posedge clk);
        model_update(s, a, b, ab, rd, r);
        #1;
        chk_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, 0);
    endtask

    function automatic logic [DW-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return DW'(1);
            default: return DW'($urandom);
        endcase
    endfunction

    initial begin
        step(0, '0, '0, 0, 0, 1);
        step(0, '0, '0, 0, 0, 1);
        idle(2);

        step(1, 16'd3, 16'd5, 0, 0, 0);
        idle(20);
        step(1, 16'hFFFF, 16'hFFFF, 0, 0, 0);
        idle(20);
        step(1, 16'h1234, 16'h0000, 0, 0, 0);
        idle(20);

        // busy_rd in the DONE cycle, then one cycle later
        step(1, 16'd7, 16'd9, 0, 0, 0);
        idle(16);
        step(0, '0, '0, 0, 1, 0);
        step(0, '0, '0, 0, 1, 0);
        idle(3);

        // abort mid-job at T+8
        step(1, 16'd100, 16'd200, 0, 0, 0);
        idle(7);
        step(0, '0, '0, 1, 0, 0);
        idle(4);

        // abort and start together in IDLE
        step(1, 16'd5, 16'd5, 1, 0, 0);
        idle(2);

        // start held every cycle
        for (int i = 0; i < 40; i++) step(1, DW'(i + 2), DW'(i + 3), 0, 0, 0);
        idle(20);

        // second start at T+4
        step(1, 16'd11, 16'd13, 0, 0, 0);
        idle(3);
        step(1, 16'd17, 16'd19, 0, 0, 0);
        idle(40);

        // reset at T+10 mid-RUN, then a fresh job
        step(1, 16'hABCD, 16'h0123, 0, 0, 0);
        idle(9);
        step(0, '0, '0, 0, 0, 1);
        idle(2);
        step(1, 16'd6, 16'd7, 0, 0, 0);
        idle(20);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) == 0, rand_op(), rand_op(),
                 $urandom_range(0, 40) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 250) == 0);
        end
        idle(25);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
